// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchronizer, mid-bit sampling FSM,
// registered byte output with single-cycle completion / framing-error strobes.
module uart_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_complete,
    output logic       rx_error
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             rxd_meta;
    logic             rxd_s;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [7:0]       shift;
    logic             shift_en;
    logic             frame_ok;
    logic             frame_bad;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_s    <= rxd_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        shift_en   = 1'b0;
        frame_ok   = 1'b0;
        frame_bad  = 1'b0;
        case (state)
            IDLE: begin
                if (!rxd_s) begin
                    state_next = START;
                end
            end
            START: begin
                // Start bit must still be low at its midpoint, otherwise it was a glitch.
                if (cnt == HALF_LAST) begin
                    state_next = rxd_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    shift_en = 1'b1;
                    if (idx == 3'd7) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    if (rxd_s) begin
                        frame_ok   = 1'b1;
                        state_next = IDLE;
                    end else begin
                        frame_bad  = 1'b1;
                        state_next = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rxd_s) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt         <= '0;
            idx         <= '0;
            shift       <= '0;
            rx_data     <= 8'h00;
            rx_complete <= 1'b0;
            rx_error    <= 1'b0;
        end else begin
            rx_complete <= frame_ok;
            rx_error    <= frame_bad;

            // Bit timer restarts on every state change and at each data-bit boundary.
            if (state_next != state || shift_en) begin
                cnt <= '0;
            end else if (state == START || state == DATA || state == STOP) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end

            if (state == START && state_next == DATA) begin
                idx <= '0;
            end else if (shift_en) begin
                idx <= idx + 3'd1;
            end

            if (shift_en) begin
                shift <= {rxd_s, shift[7:1]};
            end

            if (frame_ok) begin
                rx_data <= shift;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table of frames (fixed + random) checked against
// a frame-level timing model, plus hand sequences for glitch, mid-frame reset and break.
module tb_uart_rx;

    localparam int CPB      = 8;
    localparam int HALF     = CPB / 2;
    localparam int EVT_OFS  = 2 + HALF + 9 * CPB;
    localparam int NUM_VECS = 24;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         gap;
        logic       exp_comp;
        logic       exp_err;
        logic [7:0] exp_data;
    } vec_t;

    typedef struct {
        int         cyc;
        logic       comp;
        logic       err;
        logic [7:0] data;
    } evt_t;

    logic       clk;
    logic       rst_n;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_complete;
    logic       rx_error;

    int   cyc;
    int   vectors;
    int   miscompares;
    logic prev_strobe;
    logic [7:0] held;
    evt_t exp_q[$];
    evt_t got_q[$];
    vec_t vecs[NUM_VECS];

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rxd         (rxd),
        .rx_data     (rx_data),
        .rx_complete (rx_complete),
        .rx_error    (rx_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Records every strobe with its cycle and checks the exclusivity / single-cycle rules.
    initial prev_strobe = 1'b0;
    always @(negedge clk) begin
        if (rx_complete || rx_error) begin
            evt_t e;
            e.cyc  = cyc;
            e.comp = rx_complete;
            e.err  = rx_error;
            e.data = rx_data;
            got_q.push_back(e);
            vectors++;
            if ((rx_complete && rx_error) || prev_strobe) begin
                miscompares++;
                $display("[TB] FAIL strobe_rule: got complete=%0b error=%0b prev=%0b at cycle %0d, expected single exclusive pulse",
                         rx_complete, rx_error, prev_strobe, cyc);
            end
        end
        prev_strobe = rx_complete || rx_error;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkValue(input string name, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Drives one 8N1 frame LSB-first starting at a negedge, then 'gap' idle cycles;
    // the expected strobe lands EVT_OFS cycles after the first edge that sees the start bit.
    task automatic applyStimulus(input logic [7:0] data, input logic stop, input int gap,
                                 input logic exp_comp, input logic exp_err,
                                 input logic [7:0] exp_data);
        logic [9:0] bits;
        evt_t e;
        bits = {stop, data, 1'b0};
        e.cyc  = cyc + 1 + EVT_OFS;
        e.comp = exp_comp;
        e.err  = exp_err;
        e.data = exp_data;
        if (exp_comp || exp_err) exp_q.push_back(e);
        for (int b = 0; b < 10; b++) begin
            rxd = bits[b];
            repeat (CPB) @(negedge clk);
        end
        rxd = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [7:0] exp_rx_data);
        while (exp_q.size() > 0) begin
            evt_t x;
            x = exp_q.pop_front();
            vectors++;
            if (got_q.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL %s: got no strobe, expected comp=%0b err=%0b data=%h at cycle %0d",
                         name, x.comp, x.err, x.data, x.cyc);
            end else begin
                evt_t g;
                g = got_q.pop_front();
                if (g.cyc != x.cyc || g.comp !== x.comp || g.err !== x.err || g.data !== x.data) begin
                    miscompares++;
                    $display("[TB] FAIL %s: got comp=%0b err=%0b data=%h cycle %0d, expected comp=%0b err=%0b data=%h cycle %0d",
                             name, g.comp, g.err, g.data, g.cyc, x.comp, x.err, x.data, x.cyc);
                end
            end
        end
        while (got_q.size() > 0) begin
            evt_t g;
            g = got_q.pop_front();
            vectors++;
            miscompares++;
            $display("[TB] FAIL %s: got unexpected strobe comp=%0b err=%0b at cycle %0d, expected none",
                     name, g.comp, g.err, g.cyc);
        end
        checkValue({name, "_rx_data"}, rx_data, exp_rx_data);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rxd         = 1'b1;
        rst_n       = 1'b0;
        held        = 8'h00;

        // Fixed frames first (valid, framing error, back-to-back pair), then random ones.
        vecs[0] = '{8'h5A, 1'b1, 10, 1'b1, 1'b0, 8'h5A};
        vecs[1] = '{8'hA5, 1'b0, 10, 1'b0, 1'b1, 8'h5A};
        vecs[2] = '{8'h00, 1'b1,  0, 1'b1, 1'b0, 8'h00};
        vecs[3] = '{8'hFF, 1'b1, 10, 1'b1, 1'b0, 8'hFF};
        held = 8'hFF;
        for (int i = 4; i < NUM_VECS; i++) begin
            vecs[i].data = 8'($urandom_range(0, 255));
            vecs[i].stop = ($urandom_range(0, 3) != 0);
            vecs[i].gap  = vecs[i].stop ? int'($urandom_range(0, 12)) : int'($urandom_range(2, 12));
            if (vecs[i].stop) held = vecs[i].data;
            vecs[i].exp_comp = vecs[i].stop;
            vecs[i].exp_err  = !vecs[i].stop;
            vecs[i].exp_data = held;
        end

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkValue("reset_rx_data", rx_data, 8'h00);
        checkValue("reset_complete", {7'd0, rx_complete}, 8'h00);
        checkValue("reset_error", {7'd0, rx_error}, 8'h00);

        for (int i = 0; i < NUM_VECS; i++) begin
            applyStimulus(vecs[i].data, vecs[i].stop, vecs[i].gap,
                          vecs[i].exp_comp, vecs[i].exp_err, vecs[i].exp_data);
            checkOutput($sformatf("frame%0d", i), vecs[i].exp_data);
        end
        repeat (5) @(negedge clk);

        // Two-cycle low glitch must be rejected, then a normal frame follows.
        rxd = 1'b0;
        repeat (2) @(negedge clk);
        rxd = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("glitch", held);
        applyStimulus(8'h3C, 1'b1, 10, 1'b1, 1'b0, 8'h3C);
        checkOutput("after_glitch", 8'h3C);

        // Reset pulse in the middle of data bit 4 aborts the frame silently.
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int b = 0; b < 4; b++) begin
            rxd = 8'h81 >> b;
            repeat (CPB) @(negedge clk);
        end
        rxd = 1'b0;
        repeat (CPB / 2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rxd   = 1'b1;
        repeat (30) @(negedge clk);
        checkOutput("reset_mid_frame", 8'h00);
        applyStimulus(8'h42, 1'b1, 10, 1'b1, 1'b0, 8'h42);
        checkOutput("after_reset", 8'h42);

        // Line held low: exactly one framing error, then silence until released.
        begin
            evt_t e;
            e.cyc  = cyc + 1 + EVT_OFS;
            e.comp = 1'b0;
            e.err  = 1'b1;
            e.data = 8'h42;
            exp_q.push_back(e);
        end
        rxd = 1'b0;
        repeat (200) @(negedge clk);
        rxd = 1'b1;
        repeat (40) @(negedge clk);
        checkOutput("break", 8'h42);
        applyStimulus(8'hC3, 1'b1, 10, 1'b1, 1'b0, 8'hC3);
        checkOutput("after_break", 8'hC3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver.
- Sits directly upstream of the calculator control path and supplies the byte stream (rx_data, rx_complete, rx_error) that the command FSM consumes.
- Converts the asynchronous serial line into a registered byte plus single-cycle completion and framing-error strobes.
- Format: LSB-first, 1 start bit, 8 data bits, no parity, 1 stop bit. Start-bit glitches are rejected.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per bit (50 MHz / 115200). Legal range ≥ 4.
- HALF_BIT, CLKS_PER_BIT/2 (integer division), derived mid-bit offset. Local, not overridable.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- rxd  input  1  asynchronous serial line; idle high.
- rx_data  output  8  last correctly framed byte; registered.
- rx_complete  output  1  one-cycle pulse: new valid byte on rx_data.
- rx_error  output  1  one-cycle pulse: framing error (stop bit sampled low).

Behaviour:
- Reset (rst_n low at a clk edge):
  - Both synchronizer flops = 1; state = IDLE; bit counter, bit index and shift register = 0.
  - rx_data = 8'h00, rx_complete = 0, rx_error = 0.
  - Reset mid-frame aborts the frame silently: no strobe is produced and rx_data keeps its reset value.
- Input synchronizer:
  - Two-flop synchronizer rxd → rxd_s. Only rxd_s is used internally.
  - Total synchronizer latency is 2 cycles.
- Counter: width $clog2(CLKS_PER_BIT). Reset to 0 on every state change.
- State machine:
  - IDLE: if rxd_s == 0 → START, cnt = 0.
  - START: cnt increments each cycle. At cnt == HALF_BIT-1:
    - rxd_s == 0 → DATA, cnt = 0, idx = 0.
    - rxd_s == 1 → IDLE (glitch). No strobe.
  - DATA: cnt increments each cycle. At cnt == CLKS_PER_BIT-1:
    - Shift rxd_s into shift[7] with the register shifting right, so the first received bit ends in shift[0].
    - Increment idx, cnt = 0.
    - After the 8th sample → STOP.
  - STOP: at cnt == CLKS_PER_BIT-1:
    - rxd_s == 1 → rx_data <= shift, rx_complete = 1 for one cycle, → IDLE.
    - rxd_s == 0 → rx_error = 1 for one cycle, rx_data unchanged, → BREAK.
  - BREAK: remain until rxd_s == 1, then → IDLE. Only one rx_error is produced per low period (line held low / break condition).
- Timing:
  - Let E0 be the first clk edge that samples rxd low.
  - Data bit k (k = 0..7) is sampled at edge E0+2+HALF_BIT+(k+1)·CLKS_PER_BIT.
  - The stop bit is sampled at E0+2+HALF_BIT+9·CLKS_PER_BIT. The strobe is high for exactly the cycle following that edge.
- Strobe rules:
  - rx_complete and rx_error are never high together.
  - Neither strobe is ever high for more than one consecutive cycle.
- Back-to-back frames: IDLE is re-entered in the stop-bit sampling cycle, so a start bit beginning immediately after the nominal stop-bit midpoint is accepted with no dead time.
- Output hold: rx_data holds its value between frames. It is updated only on a valid frame.

Test Plan (CLKS_PER_BIT = 8, HALF_BIT = 4):
1. Reset, then send 0x5A → rx_data = 0x5A; rx_complete high for exactly one cycle, following edge E0+78; rx_error stays 0.
2. Send 0xA5 with the stop bit forced low → rx_error one-cycle pulse at the same timing; rx_data remains 0x5A from the previous test; no rx_complete.
3. Pulse rxd low for 2 cycles, then high → no strobe; FSM back in IDLE; a following frame 0x3C is received correctly.
4. Send 0x00 then 0xFF with no idle gap between frames → two rx_complete pulses exactly 80 cycles apart; rx_data = 0x00, then 0xFF.
5. Start 0x81 and assert rst_n low during data bit 4 for one cycle, then resume the line idle → no strobe; rx_data = 0x00; the next frame 0x42 is received correctly.
6. Hold rxd low for 200 cycles, then release → exactly one rx_error pulse; no further strobes until a new valid frame.
